// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/arith/shift ops plus iterative signed mult/div into Hi/Lo,
// with a start/busy/done handshake so the control FSM can stall on long ops.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic             invalidOp
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic                   is_div_p0, sa_p0, sb_p0;
  logic [WIDTH-1:0]       mb_p0;
  logic [2*WIDTH-1:0]     acc_p0;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sc_res;
  logic                    long_op;
  logic [WIDTH:0]          mul_sum, div_sh;
  logic [WIDTH-1:0]        div_diff;
  logic [2*WIDTH-1:0]      step_nxt, prod;
  logic [WIDTH-1:0]        quo, rem;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  assign a_s     = A;
  assign b_s     = B;
  assign long_op = (ALUCtrl == 4'd7) || ((ALUCtrl == 4'd8) && (B != '0));

  always_comb begin
    sc_res = '0;
    case (ALUCtrl)
      4'd0:    sc_res = A & B;
      4'd1:    sc_res = A | B;
      4'd2:    sc_res = A + B;
      4'd3:    sc_res = A - B;
      4'd4:    sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'd5:    sc_res = {{(WIDTH-1){1'b0}}, (a_s > b_s)};
      4'd6:    sc_res = ~A;
      4'd9:    sc_res = B << shamt;
      4'd10:   sc_res = B >> shamt;
      default: sc_res = '0;
    endcase
  end

  // Iteration step: mult adds the multiplicand into the upper half and shifts right;
  // div shifts {rem,quo} left and subtracts the divisor when it fits.
  always_comb begin
    mul_sum  = {1'b0, acc_p0[2*WIDTH-1:WIDTH]} + (acc_p0[0] ? {1'b0, mb_p0} : '0);
    div_sh   = acc_p0[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh[WIDTH-1:0] - mb_p0;
    if (is_div_p0) begin
      if (div_sh >= {1'b0, mb_p0})
        step_nxt = {div_diff, acc_p0[WIDTH-2:0], 1'b1};
      else
        step_nxt = {div_sh[WIDTH-1:0], acc_p0[WIDTH-2:0], 1'b0};
    end else begin
      step_nxt = {mul_sum, acc_p0[WIDTH-1:1]};
    end
    prod = neg2_if(acc_p0, sa_p0 ^ sb_p0);
    quo  = neg_if(acc_p0[WIDTH-1:0], sa_p0 ^ sb_p0);
    rem  = neg_if(acc_p0[2*WIDTH-1:WIDTH], sa_p0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = long_op ? CALC : DONE;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      is_div_p0 <= 1'b0;
      sa_p0     <= 1'b0;
      sb_p0     <= 1'b0;
      mb_p0     <= '0;
      acc_p0    <= '0;
      Result    <= '0;
      Zero      <= 1'b1;
      Hi        <= '0;
      Lo        <= '0;
      divByZero <= 1'b0;
      invalidOp <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt       <= '0;
          divByZero <= 1'b0;
          invalidOp <= 1'b0;
          sa_p0     <= A[WIDTH-1];
          sb_p0     <= B[WIDTH-1];
          if (ALUCtrl == 4'd7) begin
            is_div_p0 <= 1'b0;
            mb_p0     <= neg_if(A, A[WIDTH-1]);
            acc_p0    <= {{WIDTH{1'b0}}, neg_if(B, B[WIDTH-1])};
          end else if (ALUCtrl == 4'd8 && B != '0) begin
            is_div_p0 <= 1'b1;
            mb_p0     <= neg_if(B, B[WIDTH-1]);
            acc_p0    <= {{WIDTH{1'b0}}, neg_if(A, A[WIDTH-1])};
          end else if (ALUCtrl == 4'd8) begin
            divByZero <= 1'b1;
            Hi        <= A;
            Lo        <= '1;
            Result    <= '1;
            Zero      <= 1'b0;
          end else begin
            Result    <= sc_res;
            Zero      <= (sc_res == '0);
            invalidOp <= (ALUCtrl > 4'd10);
          end
        end
        CALC: begin
          cnt    <= cnt + 1'b1;
          acc_p0 <= step_nxt;
        end
        // Sign fix-up of the magnitude result, then publish to Hi/Lo/Result
        FIX: begin
          if (is_div_p0) begin
            Lo     <= quo;
            Hi     <= rem;
            Result <= quo;
            Zero   <= (quo == '0);
          end else begin
            Hi     <= prod[2*WIDTH-1:WIDTH];
            Lo     <= prod[WIDTH-1:0];
            Result <= prod[WIDTH-1:0];
            Zero   <= (prod[WIDTH-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
